instr_stream_tx: RTL and testbench

//  Transmit side of the core instruction port: buffers 32-bit instruction words pushed by a host/loader.

---
 rtl/instr_stream_tx_pkg.sv | 14 +
 rtl/instr_stream_tx_fifo.sv | 49 ++++
 rtl/instr_stream_tx.sv | 131 +++++++++++++
 tb/tb_instr_stream_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_tx_pkg.sv
// Shared types and constants for the core instruction-port transmitter.
package instr_stream_tx_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_stream_tx_fifo.sv
// Synchronous FIFO for instruction words; pointer-compare full/empty.
// Read data is combinational from the head entry; pushes while full are ignored here.
module instr_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_level
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_rdata   = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/instr_stream_tx.sv
// Streams buffered host instruction words into the core, stalling it when none are ready.
// Push-to-core latency 2 cycles; halt drains the pipeline with NOPs before reporting done.
module instr_stream_tx
  import instr_stream_tx_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_host_wr_en,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  input  logic                  i_start,
  input  logic                  i_halt_req,
  output logic                  o_host_full,
  output logic                  o_overflow,
  output logic [ADDR_W:0]       o_level,
  output logic [DATA_WIDTH-1:0] o_core_data,
  output logic                  o_core_stall,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_issue_count
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t                r_state;
  logic [DCW-1:0]        r_drain_cnt;
  logic [DATA_WIDTH-1:0] r_core_data;
  logic                  r_core_stall;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;
  logic [CNT_W-1:0]      r_issue_count;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Empty comes from registered pointers, so a word pushed this edge is popped next edge at the earliest.
  assign w_pop = (r_state == ST_RUN) && !i_halt_req && !w_empty;

  instr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_WIDTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_host_wr_en),
    .i_wdata (i_host_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_drain_cnt   <= '0;
      r_core_data   <= NOP_WORD;
      r_core_stall  <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_issue_count <= '0;
    end else begin
      if (i_host_wr_en && w_full) r_overflow <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_core_data  <= NOP_WORD;
          r_core_stall <= 1'b1;
          if (i_start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_halt_req) begin
            // The halt edge itself emits the first drain NOP.
            r_state      <= ST_DRAIN;
            r_core_data  <= NOP_WORD;
            r_core_stall <= 1'b0;
            r_drain_cnt  <= DCW'(DRAIN_CYCLES - 1);
          end else if (!w_empty) begin
            r_core_data   <= w_rdata;
            r_core_stall  <= 1'b0;
            r_issue_count <= r_issue_count + CNT_W'(1);
          end else begin
            r_core_stall <= 1'b1;
          end
        end
        ST_DRAIN: begin
          r_core_data <= NOP_WORD;
          if (r_drain_cnt == '0) begin
            r_state      <= ST_HALT;
            r_core_stall <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end else begin
            r_core_stall <= 1'b0;
            r_drain_cnt  <= r_drain_cnt - DCW'(1);
          end
        end
        ST_HALT: begin
          r_core_data  <= NOP_WORD;
          r_core_stall <= 1'b1;
          if (i_start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_host_full   = w_full;
  assign o_overflow    = r_overflow;
  assign o_core_data   = r_core_data;
  assign o_core_stall  = r_core_stall;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_issue_count = r_issue_count;

endmodule

// File: tb/tb_instr_stream_tx.sv
// Bench for instr_stream_tx: directed stimulus, expected core words queued and checked by a monitor.
module tb_instr_stream_tx;

  logic        clk;
  logic        rst_n;
  logic        host_wr_en;
  logic [31:0] host_wdata;
  logic        start;
  logic        halt_req;
  logic        host_full;
  logic        overflow;
  logic [4:0]  level;
  logic [31:0] core_data;
  logic        core_stall;
  logic        busy;
  logic        done;
  logic [15:0] issue_count;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [31:0] exp_q[$];

  instr_stream_tx #(.ADDR_W(4), .DRAIN_CYCLES(2), .CNT_W(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_host_wr_en  (host_wr_en),
    .i_host_wdata  (host_wdata),
    .i_start       (start),
    .i_halt_req    (halt_req),
    .o_host_full   (host_full),
    .o_overflow    (overflow),
    .o_level       (level),
    .o_core_data   (core_data),
    .o_core_stall  (core_stall),
    .o_busy        (busy),
    .o_done        (done),
    .o_issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    host_wr_en = 1'b1;
    host_wdata = w;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Every cycle the core is not stalled must carry the next expected word.
  always @(negedge clk) begin
    if (rst_n && !core_stall) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL stream: unexpected core_data %h with stall=0", core_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (core_data !== e) $display("FAIL stream: got %h expected %h", core_data, e);
        else n_pass++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; host_wr_en = 1'b0; host_wdata = '0; start = 1'b0; halt_req = 1'b0;
    #23;
    chk("rst_stall", 32'(core_stall), 32'd1);
    chk("rst_data", core_data, 32'h0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(host_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_count", 32'(issue_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Reset while running with five words buffered.
    for (int i = 0; i < 5; i++) push_word(32'hDEAD_0000 + 32'(i));
    pulse_start();
    chk("t1_level_pre", 32'(level), 32'd5);
    chk("t1_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #2;
    chk("t1_stall", 32'(core_stall), 32'd1);
    chk("t1_data", core_data, 32'h0);
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_count", 32'(issue_count), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Three words then start: back-to-back issue.
    exp_q.push_back(32'h00A1); exp_q.push_back(32'h00A2); exp_q.push_back(32'h00A3);
    push_word(32'h00A1); push_word(32'h00A2); push_word(32'h00A3);
    pulse_start();
    chk("t2_stall_start", 32'(core_stall), 32'd1);
    tick(); chk("t2_w1", core_data, 32'h00A1);
    tick(); chk("t2_w2", core_data, 32'h00A2);
    tick(); chk("t2_w3", core_data, 32'h00A3);
    tick();
    chk("t2_stall_after", 32'(core_stall), 32'd1);
    chk("t2_count", 32'(issue_count), 32'd3);

    // Push into an empty FIFO while running: visible two edges later.
    exp_q.push_back(32'h1234);
    host_wr_en = 1'b1; host_wdata = 32'h1234;
    tick();
    host_wr_en = 1'b0;
    chk("t4_stall_n1", 32'(core_stall), 32'd1);
    tick();
    chk("t4_data_n2", core_data, 32'h1234);
    chk("t4_stall_n2", 32'(core_stall), 32'd0);
    tick();
    chk("t4_count", 32'(issue_count), 32'd4);

    // Halt with an empty FIFO to get to HALT without pops.
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    tick(); tick();
    chk("halt_done", 32'(done), 32'd1);

    // Fill past capacity.
    for (int i = 1; i <= 17; i++) begin
      push_word(32'h100 + 32'(i));
      if (i == 15) chk("t3_full15", 32'(host_full), 32'd0);
      if (i == 16) begin
        chk("t3_full16", 32'(host_full), 32'd1);
        chk("t3_ovf16", 32'(overflow), 32'd0);
      end
    end
    chk("t3_ovf17", 32'(overflow), 32'd1);
    chk("t3_level", 32'(level), 32'd16);

    // Resume, issue 12, then halt and start together with 4 left.
    for (int i = 1; i <= 12; i++) exp_q.push_back(32'h100 + 32'(i));
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    pulse_start();
    for (int i = 0; i < 12; i++) tick();
    chk("t5_level_pre", 32'(level), 32'd4);
    halt_req = 1'b1; start = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("t6_level_nopop", 32'(level), 32'd4);
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_nop_stall", 32'(core_stall), 32'd0);
    tick();
    start = 1'b0;
    chk("t5_nop2_stall", 32'(core_stall), 32'd0);
    chk("t5_nop2_done", 32'(done), 32'd0);
    tick();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_stall", 32'(core_stall), 32'd1);
    chk("t5_level", 32'(level), 32'd4);
    chk("t5_count_mid", 32'(issue_count), 32'd16);
    for (int i = 13; i <= 16; i++) exp_q.push_back(32'h100 + 32'(i));
    pulse_start();
    for (int i = 0; i < 6; i++) tick();
    chk("t5_count_end", 32'(issue_count), 32'd20);
    chk("t5_level_end", 32'(level), 32'd0);
    chk("t5_stall_end", 32'(core_stall), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
